// File: rtl/ce_pkg.sv
// Shared types and width helpers for the CE scheduler slice.
package ce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WWAIT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned CL_OUT_DEF = 4;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned OUT_H_DEF  = 8;
  localparam int unsigned W_LAT_DEF  = 2;
  localparam int unsigned CE_LAT_DEF = 4;

  // Ceiling log2, never below 1 so single-value fields keep a legal width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ce_sched_xy_cnt.sv
// Raster window counter: x advances per enable, wraps into y; flags the final position.
module ce_sched_xy_cnt import ce_pkg::*; #(
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned OUT_H = OUT_H_DEF,
  localparam int unsigned XW = clog2(OUT_W),
  localparam int unsigned YW = clog2(OUT_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(OUT_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/ce_sched.sv
// Sequences one CE engine over an output map: weight fetch, window stream, pipeline drain per filter.
module ce_sched import ce_pkg::*; #(
  parameter int unsigned CL_OUT = CL_OUT_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned OUT_H  = OUT_H_DEF,
  parameter int unsigned W_LAT  = W_LAT_DEF,
  parameter int unsigned CE_LAT = CE_LAT_DEF,
  localparam int unsigned FW = clog2(CL_OUT),
  localparam int unsigned XW = clog2(OUT_W),
  localparam int unsigned YW = clog2(OUT_H),
  localparam int unsigned AW = clog2(CL_OUT * OUT_W * OUT_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          w_rd_en,
  output logic [FW-1:0] w_rd_addr,
  output logic          w_load,
  input  logic          win_valid,
  output logic          win_ready,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          ce_en_in,
  input  logic          ce_en_out,
  output logic          res_we,
  output logic [AW-1:0] res_addr
);

  localparam int unsigned OW = clog2(CE_LAT + 2);
  localparam int unsigned LW = clog2(W_LAT + 1);
  localparam int unsigned TW = clog2(4 * CE_LAT);
  localparam logic [TW-1:0] TMO_MAX  = TW'(4 * CE_LAT - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(CL_OUT - 1);

  state_t        state;
  logic [FW-1:0] filt;
  logic [LW-1:0] lat_cnt;
  logic [OW-1:0] outst;
  logic [TW-1:0] tmo;
  logic [AW-1:0] res_cnt;
  logic          start_acc;
  logic          out_ok;
  logic          stray;
  logic          tmo_fire;
  logic          xy_last;

  assign start_acc = (state == ST_IDLE) && start;
  assign out_ok    = ce_en_out && (outst != '0);
  assign stray     = ce_en_out && (outst == '0);
  assign tmo_fire  = (state == ST_DRAIN) && !ce_en_out && (outst != '0) && (tmo == TMO_MAX);

  assign ce_en_in  = win_valid & win_ready;
  assign res_we    = out_ok & busy;
  assign w_rd_addr = filt;
  assign res_addr  = res_cnt;

  ce_sched_xy_cnt #(
    .OUT_W(OUT_W),
    .OUT_H(OUT_H)
  ) u_xy (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (ce_en_in),
    .x   (win_x),
    .y   (win_y),
    .last(xy_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      w_rd_en   <= 1'b0;
      w_load    <= 1'b0;
      win_ready <= 1'b0;
      filt      <= '0;
      lat_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      w_rd_en <= 1'b0;
      w_load  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_WREQ;
            busy    <= 1'b1;
            w_rd_en <= 1'b1;
            filt    <= '0;
            err     <= 1'b0;
          end
        end
        ST_WREQ: begin
          state   <= ST_WWAIT;
          lat_cnt <= LW'(1);
          w_load  <= (W_LAT == 1);
        end
        // w_load is raised one cycle early so it appears on the final WWAIT cycle.
        ST_WWAIT: begin
          if (lat_cnt == LW'(W_LAT)) begin
            state     <= ST_STREAM;
            win_ready <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
            w_load  <= ((lat_cnt + LW'(1)) == LW'(W_LAT));
          end
        end
        ST_STREAM: begin
          if (ce_en_in && xy_last) begin
            state     <= ST_DRAIN;
            win_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (tmo_fire) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (outst == '0) begin
            if (filt == FILT_MAX) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              filt    <= filt + FW'(1);
              state   <= ST_WREQ;
              w_rd_en <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          win_ready <= 1'b0;
        end
      endcase
      if (stray) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst   <= '0;
      tmo     <= '0;
      res_cnt <= '0;
    end else begin
      if (start_acc || tmo_fire) begin
        outst <= '0;
      end else if (ce_en_in && !out_ok) begin
        outst <= outst + OW'(1);
      end else if (!ce_en_in && out_ok) begin
        outst <= outst - OW'(1);
      end

      if ((state != ST_DRAIN) || ce_en_out) begin
        tmo <= '0;
      end else if (outst != '0) begin
        tmo <= tmo + TW'(1);
      end

      if (start_acc) begin
        res_cnt <= '0;
      end else if (res_we) begin
        res_cnt <= res_cnt + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ce_sched.sv
// Directed bench for ce_sched with a 4-stage CE en delay-line model.
module tb_ce_sched;

  localparam int CL_OUT = 2;
  localparam int OUT_W  = 2;
  localparam int OUT_H  = 2;
  localparam int W_LAT  = 2;
  localparam int CE_LAT = 4;
  localparam int NRES   = CL_OUT * OUT_W * OUT_H;

  logic       clk = 1'b0;
  logic       rst, start, win_valid, ce_en_out;
  logic       busy, done, err, w_rd_en, w_load, win_ready, ce_en_in, res_we;
  logic [0:0] w_rd_addr, win_x, win_y;
  logic [2:0] res_addr;

  always #5 clk = ~clk;

  ce_sched #(
    .CL_OUT(CL_OUT), .OUT_W(OUT_W), .OUT_H(OUT_H), .W_LAT(W_LAT), .CE_LAT(CE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_load(w_load),
    .win_valid(win_valid), .win_ready(win_ready), .win_x(win_x), .win_y(win_y),
    .ce_en_in(ce_en_in), .ce_en_out(ce_en_out), .res_we(res_we), .res_addr(res_addr)
  );

  // CE model: en_in delayed CE_LAT cycles; pulse number drop_at is swallowed, extra injects one.
  logic [CE_LAT-1:0] pipe;
  int   out_idx = 0;
  int   drop_at = -1;
  logic extra;

  always @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else begin
      pipe <= {pipe[CE_LAT-2:0], ce_en_in};
      if (pipe[CE_LAT-1]) out_idx <= out_idx + 1;
    end
  end
  assign ce_en_out = (pipe[CE_LAT-1] && (out_idx != drop_at)) || extra;

  typedef struct {
    logic        st;
    logic        wv;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [0:26];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, wrd_cyc = 0, en_idx = 0, exp_addr = 0, last_eo = 0, err_cyc = 0;
  int   n_en = 0, n_res = 0, n_done = 0;
  int   s_en, s_res, s_done, phase;
  bit   err_seen, toggle_mode, sp, found;

  function automatic vec_t mk(input logic st, wv, bz, re, ra, wl, rdy, x, y, ei, we,
                              input int addr, input logic dn);
    vec_t v;
    v.st  = st;
    v.wv  = wv;
    v.exp = {bz, re, ra, wl, rdy, x, y, ei, we, 3'(addr), dn, 1'b0};
    return v;
  endfunction

  function automatic logic [13:0] act_vec();
    return {busy, w_rd_en, w_rd_addr, w_load, win_ready, win_x, win_y,
            ce_en_in, res_we, res_addr, done, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Negedge sample plus running protocol checks.
  task automatic sample();
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (ce_en_out) last_eo = cyc;
      if (err && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
      if (w_rd_en) begin
        wrd_cyc = cyc;
        en_idx  = 0;
        if (w_rd_addr == 1'b0) exp_addr = 0;
      end
      if (w_load) check("w_load latency", cyc - wrd_cyc, W_LAT);
      if (win_ready && !win_valid) check("en_in during stall", ce_en_in, 0);
      if (ce_en_in) begin
        check("window x", win_x, en_idx % OUT_W);
        check("window y", win_y, en_idx / OUT_W);
        en_idx++;
        n_en++;
      end
      if (res_we) begin
        check("res_addr", res_addr, exp_addr);
        exp_addr = (exp_addr + 1) % NRES;
        n_res++;
      end
      if (done) n_done++;
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_en = n_en; s_res = n_res; s_done = n_done;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      win_valid = toggle_mode ? (phase % 3 == 0) : 1'b1;
      phase++;
      tick();
      k++;
    end
    check({name, " ends within budget"}, busy, 0);
  endtask

  task automatic run_counts(input string name, input int en, input int res, input int dn);
    check({name, " en_in count"}, n_en - s_en, en);
    check({name, " res_we count"}, n_res - s_res, res);
    check({name, " done count"}, n_done - s_done, dn);
  endtask

  initial begin
    //                 st wv bz re ra wl rdy x y ei we addr dn
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[10] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    tbl[13] = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0);
    tbl[14] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0);
    tbl[15] = mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0);
    tbl[16] = mk(0, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 4, 0);
    tbl[17] = mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0, 4, 0);
    tbl[18] = mk(0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 4, 0);
    tbl[19] = mk(0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 4, 0);
    tbl[20] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 4, 0);
    tbl[21] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 5, 0);
    tbl[22] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 6, 0);
    tbl[23] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 7, 0);
    tbl[24] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[25] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[26] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; start = 1'b0; win_valid = 1'b0; extra = 1'b0;
    toggle_mode = 1'b0; phase = 0; err_seen = 1'b0;
    #12;
    check("reset state", act_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Full run, cycle-exact against the table.
    snap();
    for (int i = 0; i < 27; i++) begin
      start     = tbl[i].st;
      win_valid = tbl[i].wv;
      sample();
      check($sformatf("table cycle %0d", i), act_vec(), tbl[i].exp);
      @(posedge clk); #1;
    end
    start = 1'b0;
    run_counts("table run", 2 * OUT_W * OUT_H, NRES, 1);

    // Windows offered only every third cycle.
    toggle_mode = 1'b1; phase = 0;
    snap();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("stall run", 300);
    run_counts("stall run", 2 * OUT_W * OUT_H, NRES, 1);
    check("stall run err", err, 0);
    toggle_mode = 1'b0;

    // start pulses during STREAM and during DONE must be ignored.
    snap();
    win_valid = 1'b1; sp = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) start = 1'b1;
      else if (win_ready && !sp) begin start = 1'b1; sp = 1'b1; end
      else start = 1'b0;
      tick();
      start = 1'b0;
      if (!busy) break;
    end
    tick(); tick();
    check("start in DONE ignored", busy, 0);
    run_counts("ignored-start run", 2 * OUT_W * OUT_H, NRES, 1);
    snap();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("second run", 100);
    run_counts("second run", 2 * OUT_W * OUT_H, NRES, 1);
    check("second run err", err, 0);

    // Stray en_out while idle.
    extra = 1'b1;
    sample();
    check("stray en_out res_we", res_we, 0);
    @(posedge clk); #1;
    extra = 1'b0;
    check("stray en_out err", err, 1);

    // Asynchronous reset in the middle of filter 1's stream.
    start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (w_rd_addr == 1'b1 && win_ready) begin found = 1'b1; break; end
      tick();
    end
    check("reached filter 1 stream", found, 1);
    #2 rst = 1'b1;
    #1 check("async reset mid-clock", act_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    snap();
    start = 1'b1; tick(); start = 1'b0;
    check("restart fetches filter 0", {w_rd_en, w_rd_addr}, 2'b10);
    wait_idle("post-reset run", 100);
    run_counts("post-reset run", 2 * OUT_W * OUT_H, NRES, 1);

    // Lost en_out forces a DRAIN timeout.
    snap();
    drop_at = out_idx;
    start = 1'b1; tick(); start = 1'b0;
    err_seen = 1'b0;
    for (int k = 0; k < 200 && !err_seen; k++) tick();
    check("timeout raises err", err_seen, 1);
    check("timeout quiet cycles", err_cyc - last_eo, 4 * CE_LAT + 1);
    check("timeout returns idle", busy, 0);
    check("timeout no done", n_done - s_done, 0);
    extra = 1'b1;
    sample();
    check("stray after timeout res_we", res_we, 0);
    @(posedge clk); #1;
    extra = 1'b0;
    check("err sticky", err, 1);

    // Clean run after a partial one: address counter must restart at 0.
    snap();
    start = 1'b1; tick(); start = 1'b0;
    check("start clears err", err, 0);
    wait_idle("final run", 100);
    run_counts("final run", 2 * OUT_W * OUT_H, NRES, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
